// File: rtl/universal_register_pkg.sv
// Shared Nano CPU operating-register definitions: op encodings used by the
// control unit, the register itself and its testbench.
package universal_register_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_e;

endpackage

// File: rtl/universal_register.sv
// N-bit operating register: hold / load / clear / shift / rotate / count in
// place, with a sticky registered carry-borrow-shift-out flag and a zero flag.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [2:0]   op,
  input  logic [N-1:0] d,
  input  logic         sin,
  output logic [N-1:0] q,
  output logic         cout,
  output logic         zero
);

  if (N < 2) begin : g_bad_width
    $error("universal_register: N must be at least 2");
  end

  localparam logic [N:0] ONE = (N+1)'(1);

  logic [N-1:0] next_q;
  logic         next_cout;
  logic [N:0]   inc_w;
  logic [N:0]   dec_w;

  // One extra bit on the counters: bit N is the carry for INC and the borrow
  // for DEC (0 - 1 sets every bit including bit N).
  assign inc_w = {1'b0, q} + ONE;
  assign dec_w = {1'b0, q} - ONE;

  // Next-state selection from the op; everything is based on the pre-edge q,
  // and HOLD / en = 0 leave cout untouched so it stays sticky.
  always_comb begin
    next_q    = q;
    next_cout = cout;
    if (en) begin
      case (op)
        OP_HOLD: begin
          next_q    = q;
          next_cout = cout;
        end
        OP_LOAD: begin
          next_q    = d;
          next_cout = 1'b0;
        end
        OP_CLR: begin
          next_q    = '0;
          next_cout = 1'b0;
        end
        OP_SHL: begin
          next_q    = {q[N-2:0], sin};
          next_cout = q[N-1];
        end
        OP_SHR: begin
          next_q    = {sin, q[N-1:1]};
          next_cout = q[0];
        end
        OP_ROL: begin
          next_q    = {q[N-2:0], q[N-1]};
          next_cout = q[N-1];
        end
        OP_INC: begin
          next_q    = inc_w[N-1:0];
          next_cout = inc_w[N];
        end
        OP_DEC: begin
          next_q    = dec_w[N-1:0];
          next_cout = dec_w[N];
        end
        default: begin
          next_q    = q;
          next_cout = cout;
        end
      endcase
    end
  end

  // State register; asynchronous reset wins over any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= RST_VAL;
      cout <= 1'b0;
    end else begin
      q    <= next_q;
      cout <= next_cout;
    end
  end

  assign zero = ~|q;

endmodule
